// File: rtl/cpu_dma_queue_regs_pkg.sv
// Shared constants for the DMA queue statistics register block:
// per-channel register indices, ctrl bit positions and the bad-address read value.
package cpu_dma_queue_regs_pkg;

  localparam logic [2:0] IDX_TX_TIMEOUT = 3'd0;
  localparam logic [2:0] IDX_TX_PKT     = 3'd1;
  localparam logic [2:0] IDX_RX_PKT     = 3'd2;
  localparam logic [2:0] IDX_RX_DROP    = 3'd3;
  localparam logic [2:0] IDX_CTRL       = 3'd4;
  localparam logic [2:0] IDX_SAT        = 3'd5;

  localparam int CTRL_WD_EN_BIT      = 0;
  localparam int CTRL_CLR_ON_RD_BIT  = 1;

  localparam logic [31:0] BAD_ADDR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dma_chan_stat_cnt.sv
// One channel's four saturating event counters plus the sticky saturation flags.
// Counter k counts i_evt[k]; a load beats a clear-on-read, which beats counting.
module dma_chan_stat_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                i_evt,
  input  logic [3:0]                i_load,
  input  logic [3:0]                i_rd_clr,
  input  logic [3:0]                i_sat_clr,
  input  logic [CNT_WIDTH-1:0]      i_load_data,
  output logic [3:0][CNT_WIDTH-1:0] o_cnt,
  output logic [3:0]                o_sat
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [3:0][CNT_WIDTH-1:0] r_cnt;
  logic [3:0]                r_sat;
  logic [3:0]                w_sat_set;

  // An event landing on an all-ones counter is the overflow that gets flagged.
  always_comb begin
    w_sat_set = '0;
    for (int k = 0; k < 4; k++) begin
      w_sat_set[k] = i_evt[k] && (r_cnt[k] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_sat <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (i_load[k]) begin
          r_cnt[k] <= i_load_data;
        end else if (i_rd_clr[k]) begin
          r_cnt[k] <= i_evt[k] ? CNT_ONE : '0;
        end else if (i_evt[k] && !w_sat_set[k]) begin
          r_cnt[k] <= r_cnt[k] + CNT_ONE;
        end
      end
      r_sat <= (r_sat & ~i_sat_clr) | w_sat_set;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = r_sat;

endmodule

// File: rtl/cpu_dma_queue_stats_regs.sv
// CPU register window onto per-channel DMA queue statistics counters, watchdog
// enables and clear-on-read control; one access per rising edge of reg_req.
module cpu_dma_queue_stats_regs
  import cpu_dma_queue_regs_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CHANNELS-1:0]   tx_timeout,
  input  logic [NUM_CHANNELS-1:0]   tx_pkt,
  input  logic [NUM_CHANNELS-1:0]   rx_pkt,
  input  logic [NUM_CHANNELS-1:0]   rx_drop,
  input  logic                      reg_req,
  input  logic                      reg_rd_wr_L,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]               reg_wr_data,
  output logic [31:0]               reg_rd_data,
  output logic                      reg_ack,
  output logic [NUM_CHANNELS-1:0]   wd_enable
);

  // Handshake: reg_req is a level held by the requester until it sees reg_ack.
  // Only a 0->1 edge of reg_req starts an access, so a held request is acked
  // exactly once; reg_ack pulses the cycle after that edge with reg_rd_data valid.
  logic                      r_req_d;
  logic                      r_ack;
  logic [31:0]               r_rd_data;
  logic [NUM_CHANNELS-1:0]   r_wd_en;
  logic [NUM_CHANNELS-1:0]   r_cor;

  logic                      w_start;
  logic [2:0]                w_idx;
  logic [REG_ADDR_WIDTH-1:0] w_chan;
  logic [NUM_CHANNELS-1:0]   w_sel;
  logic [31:0]               w_rd_val;
  logic                      w_unused_wr;

  logic [3:0][CNT_WIDTH-1:0] w_cnt [NUM_CHANNELS];
  logic [3:0]                w_sat [NUM_CHANNELS];

  assign w_start     = reg_req && !r_req_d;
  assign w_idx       = reg_addr[2:0];
  assign w_chan      = reg_addr >> 3;
  assign w_unused_wr = ^reg_wr_data;

  // Upper address bits are part of w_chan, so a nonzero upper field selects nothing.
  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_sel[c] = (w_chan == REG_ADDR_WIDTH'(c));
    end
  end

  always_comb begin
    w_rd_val = BAD_ADDR_DATA;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_sel[c]) begin
        case (w_idx)
          IDX_TX_TIMEOUT, IDX_TX_PKT, IDX_RX_PKT, IDX_RX_DROP:
            w_rd_val = 32'(w_cnt[c][w_idx[1:0]]);
          IDX_CTRL: w_rd_val = {30'd0, r_cor[c], r_wd_en[c]};
          IDX_SAT:  w_rd_val = {28'd0, w_sat[c]};
          default:  w_rd_val = BAD_ADDR_DATA;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_d   <= 1'b0;
      r_ack     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_req_d <= reg_req;
      r_ack   <= w_start;
      if (w_start && reg_rd_wr_L) begin
        r_rd_data <= w_rd_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_en <= '1;
      r_cor   <= '0;
    end else if (w_start && !reg_rd_wr_L && (w_idx == IDX_CTRL)) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (w_sel[c]) begin
          r_wd_en[c] <= reg_wr_data[CTRL_WD_EN_BIT];
          r_cor[c]   <= reg_wr_data[CTRL_CLR_ON_RD_BIT];
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic [3:0] w_evt;
    logic [3:0] w_ld;
    logic [3:0] w_clr;
    logic [3:0] w_sclr;

    assign w_evt = {rx_drop[c], rx_pkt[c], tx_pkt[c], tx_timeout[c]};

    // Index bit 2 clear means one of the four counters.
    always_comb begin
      w_ld   = '0;
      w_clr  = '0;
      w_sclr = '0;
      if (w_start && w_sel[c]) begin
        if (!reg_rd_wr_L) begin
          if (!w_idx[2]) w_ld[w_idx[1:0]] = 1'b1;
          if (w_idx == IDX_SAT) w_sclr = reg_wr_data[3:0];
        end else if (r_cor[c] && !w_idx[2]) begin
          w_clr[w_idx[1:0]] = 1'b1;
        end
      end
    end

    dma_chan_stat_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_evt       (w_evt),
      .i_load      (w_ld),
      .i_rd_clr    (w_clr),
      .i_sat_clr   (w_sclr),
      .i_load_data (reg_wr_data[CNT_WIDTH-1:0]),
      .o_cnt       (w_cnt[c]),
      .o_sat       (w_sat[c])
    );
  end

  assign reg_rd_data = r_rd_data;
  assign reg_ack     = r_ack;
  assign wd_enable   = r_wd_en;

endmodule
